maze_generator_param: RTL and testbench
=======================================

MAZE_GENERATOR_PARAM -- requirements
Module: maze_generator_param

Interface
REQ-001 Parameter W, 10, maze width in cells (2..32).
REQ-002 Parameter H, 15, maze height in cells (2..32).
REQ-003 Parameter OPEN_ENDS, 1, when 1 the entry and exit border walls are opened at INIT.
REQ-004 Parameter ENTRY_COL, 0, column of the opened top border wall (0..W-1).
REQ-005 Parameter EXIT_COL, W-1, column of the opened bottom border wall (0..W-1).
REQ-006 clk  input  1  single clock, all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 start  input  1  generation request, sampled only in IDLE.
REQ-009 rnd  input  8  random byte, fed from random_byte and sampled every PICK cycle.
REQ-010 h_walls  output  (H+1)*W  horizontal walls; bit r*W+c is the wall above cell (r,c), and row H is the bottom border.
REQ-011 v_walls  output  H*(W+1)  vertical walls; bit r*(W+1)+c is the wall left of cell (r,c), and column W is the right border.
REQ-012 busy  output  1  high while generation is in progress.
REQ-013 done  output  1  one-cycle pulse when a maze completes.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, INIT, PICK, DONE; all outputs registered.
REQ-015 IDLE: busy=0, done=0; start=1 -> INIT; otherwise stay; walls hold last maze.
REQ-016 INIT (1 cycle): all wall bits=1, visited=0, cur=cell 0 (row 0, col 0), visited[0]=1, sp=0.
REQ-017 INIT with OPEN_ENDS=1: h_walls[ENTRY_COL]=0 and h_walls[H*W+EXIT_COL]=0 in the same cycle; -> PICK.
REQ-018 PICK computes candidate mask of in-bounds unvisited neighbours, order N,E,S,W (dir codes 0..3).
REQ-019 Nonzero mask: scan from dir rnd[1:0], rotating N->E->S->W->N, first candidate wins.
REQ-020 Nonzero mask action (same cycle): clear the shared wall, push cur, mark neighbour visited, cur=neighbour.
REQ-021 Zero mask and sp>0: cur=stack[sp-1], sp=sp-1, walls unchanged.
REQ-022 Zero mask and sp==0 -> DONE.
REQ-023 DONE (1 cycle): busy=0, done=1; -> IDLE.
REQ-024 busy SHALL be 1 in INIT and PICK only; with N=W*H, busy is high for exactly 2N consecutive cycles (1 INIT + 2N-1 PICK).
REQ-025 Stack depth N-1 entries, each ceil(log2 N) bits; overflow impossible by construction; sp width ceil(log2 N).
REQ-026 start while busy or in DONE SHALL be ignored.
REQ-027 Finished maze SHALL be a spanning tree: exactly N-1 interior walls cleared; border walls untouched except REQ-017.
REQ-028 Output SHALL be a pure function of the rnd sequence across PICK cycles.

Reset
REQ-029 rst low: immediately IDLE, busy=0, done=0, all wall bits=1, visited=0, sp=0, cur=0.
REQ-030 rst low mid-generation: abort, no done pulse; next start after release generates a fresh maze.
REQ-031 No output toggles in the first cycle after rst release unless start=1.

Structure
REQ-032 Package maze_pkg: state encoding, direction codes N/E/S/W=0..3, clog2 function.
REQ-033 One sub-module maze_dir_pick (combinational): 4-bit mask + 2-bit start dir -> valid + 2-bit dir.
REQ-034 Cell/wall index arithmetic stays in maze_generator_param; no memories, registers only.

Verification
REQ-035 Reset: rst=0 -> h_walls all 1, v_walls all 1, busy=0, done=0 with no clock edge.
REQ-036 W=10,H=15, random_byte seed 217, one start pulse -> busy high exactly 300 cycles, then done=1 for 1 cycle; interior walls cleared = 149; h_walls[0]=0 and h_walls[159]=0; all other border bits=1; BFS from (0,0) reaches all 150 cells.
REQ-037 W=2,H=2, rnd held 0 -> N carve invalid, E carves (0,0)->(0,1), then S to (1,1), then W to (1,0); busy 8 cycles; v_walls[1]=0, h_walls[3]=0, v_walls[4]=0, and all other interior bits=1.
REQ-038 Same seed, two back-to-back runs with the rnd stream replayed -> bit-identical h_walls/v_walls.
REQ-039 rst pulsed low at PICK cycle 50 -> walls all 1, busy=0, no done; new start -> complete 300-cycle run.
REQ-040 start held high during a run -> ignored; exactly one done per run; start still high in IDLE -> new run begins.

Source files
------------

// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared state encoding, direction codes and sizing helper for the maze generator
package maze_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      PICK = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [1:0] DIR_N = 2'd0;
   localparam logic [1:0] DIR_E = 2'd1;
   localparam logic [1:0] DIR_S = 2'd2;
   localparam logic [1:0] DIR_W = 2'd3;

   // ceil(log2(value)), never less than 1 so every derived vector has a bit
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/maze_dir_pick.sv
// rtl/maze_dir_pick.sv - rotating first-candidate selector over the N/E/S/W neighbour mask
module maze_dir_pick (
   input  logic [3:0] mask,
   input  logic [1:0] start_dir,
   output logic       valid,
   output logic [1:0] dir
);

   logic [1:0] probe;

   // walk the rotation backwards so the candidate nearest start_dir is written last and wins
   always_comb begin
      valid = |mask;
      dir   = start_dir;
      probe = start_dir;
      for (int i = 3; i >= 0; i--) begin
         probe = start_dir + 2'(i);
         if (mask[probe]) dir = probe;
      end
   end

endmodule

// File: rtl/maze_generator_param.sv
// rtl/maze_generator_param.sv - depth-first backtracking maze generator with registered wall map
module maze_generator_param
   import maze_pkg::*;
#(
   parameter int W         = 10,
   parameter int H         = 15,
   parameter int OPEN_ENDS = 1,
   parameter int ENTRY_COL = 0,
   parameter int EXIT_COL  = W - 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [7:0]           rnd,
   output logic [(H+1)*W-1:0]   h_walls,
   output logic [H*(W+1)-1:0]   v_walls,
   output logic                 busy,
   output logic                 done
);

   localparam int N   = W * H;
   localparam int CW  = clog2(N);
   localparam int HB  = (H + 1) * W;
   localparam int VB  = H * (W + 1);
   localparam int HIW = clog2(HB);
   localparam int VIW = clog2(VB);

   state_t           state_q, state_d;
   logic [CW-1:0]    cur_q, cur_d;
   logic [CW-1:0]    sp_q, sp_d;
   logic [N-1:0]     vis_q, vis_d;
   logic [CW-1:0]    stack_q [N-1];
   logic [CW-1:0]    stack_d [N-1];
   logic [HB-1:0]    h_q, h_d;
   logic [VB-1:0]    v_q, v_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   int               cur_i, row_i, col_i;
   logic [CW-1:0]    nb_n, nb_e, nb_s, nb_w, nb_sel;
   logic [3:0]       cand;
   logic             pick_valid;
   logic [1:0]       pick_dir;
   logic             wall_is_h;
   logic [HIW-1:0]   h_idx;
   logic [VIW-1:0]   v_idx;

   // only the two low bits of the random byte steer the walk
   logic             unused_rnd_hi;
   assign unused_rnd_hi = ^rnd[7:2];

   // neighbour cells of the current cell and which of them are in bounds and still unvisited
   always_comb begin
      cur_i = int'(cur_q);
      row_i = cur_i / W;
      col_i = cur_i % W;
      nb_n  = CW'(cur_i - W);
      nb_e  = CW'(cur_i + 1);
      nb_s  = CW'(cur_i + W);
      nb_w  = CW'(cur_i - 1);
      cand[DIR_N] = (row_i > 0)     && !vis_q[nb_n];
      cand[DIR_E] = (col_i < W - 1) && !vis_q[nb_e];
      cand[DIR_S] = (row_i < H - 1) && !vis_q[nb_s];
      cand[DIR_W] = (col_i > 0)     && !vis_q[nb_w];
   end

   maze_dir_pick u_pick (
      .mask      (cand),
      .start_dir (rnd[1:0]),
      .valid     (pick_valid),
      .dir       (pick_dir)
   );

   // target cell and the wall shared with it for the chosen direction
   always_comb begin
      nb_sel    = nb_n;
      wall_is_h = 1'b1;
      h_idx     = HIW'(cur_i);
      v_idx     = '0;
      case (pick_dir)
         DIR_N: begin
            nb_sel    = nb_n;
            wall_is_h = 1'b1;
            h_idx     = HIW'(cur_i);
         end
         DIR_E: begin
            nb_sel    = nb_e;
            wall_is_h = 1'b0;
            v_idx     = VIW'(row_i * (W + 1) + col_i + 1);
         end
         DIR_S: begin
            nb_sel    = nb_s;
            wall_is_h = 1'b1;
            h_idx     = HIW'(cur_i + W);
         end
         DIR_W: begin
            nb_sel    = nb_w;
            wall_is_h = 1'b0;
            v_idx     = VIW'(row_i * (W + 1) + col_i);
         end
      endcase
   end

   // next-state logic: carve forward when possible, otherwise backtrack, otherwise finish
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      sp_d    = sp_q;
      vis_d   = vis_q;
      stack_d = stack_q;
      h_d     = h_q;
      v_d     = v_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = INIT;
         end
         INIT: begin
            h_d   = '1;
            v_d   = '1;
            vis_d = N'(1);
            cur_d = '0;
            sp_d  = '0;
            if (OPEN_ENDS != 0) begin
               h_d[ENTRY_COL]         = 1'b0;
               h_d[H * W + EXIT_COL]  = 1'b0;
            end
            state_d = PICK;
         end
         PICK: begin
            if (pick_valid) begin
               if (wall_is_h) h_d[h_idx] = 1'b0;
               else           v_d[v_idx] = 1'b0;
               stack_d[sp_q] = cur_q;
               sp_d          = sp_q + CW'(1);
               vis_d[nb_sel] = 1'b1;
               cur_d         = nb_sel;
            end else if (sp_q != '0) begin
               cur_d = stack_q[sp_q - CW'(1)];
               sp_d  = sp_q - CW'(1);
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == INIT) || (state_d == PICK);
      done_d = (state_d == DONE);
   end

   // state and wall registers; reset leaves a fully walled grid and an idle machine
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cur_q   <= '0;
         sp_q    <= '0;
         vis_q   <= '0;
         stack_q <= '{default: '0};
         h_q     <= '1;
         v_q     <= '1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         sp_q    <= sp_d;
         vis_q   <= vis_d;
         stack_q <= stack_d;
         h_q     <= h_d;
         v_q     <= v_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign h_walls = h_q;
   assign v_walls = v_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_maze_generator_param.sv
// tb/tb_maze_generator_param.sv - self-checking bench for maze_generator_param
module tb_maze_generator_param;

   localparam int WA = 10;
   localparam int HA = 15;
   localparam int NA = WA * HA;
   localparam int WB = 2;
   localparam int HB = 2;
   localparam int NB = WB * HB;
   localparam int NSEQ = 2 * NA - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_a = 1'b0;
   logic start_b = 1'b0;
   logic [7:0] rnd_a = 8'h00;
   logic [7:0] rnd_b = 8'h00;
   logic [(HA+1)*WA-1:0] h_a;
   logic [HA*(WA+1)-1:0] v_a;
   logic [(HB+1)*WB-1:0] h_b;
   logic [HB*(WB+1)-1:0] v_b;
   logic busy_a, done_a, busy_b, done_b;

   logic [7:0] seq [NSEQ];
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   maze_generator_param #(.W(WA), .H(HA)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .rnd(rnd_a),
      .h_walls(h_a), .v_walls(v_a), .busy(busy_a), .done(done_a)
   );

   maze_generator_param #(.W(WB), .H(HB)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .rnd(rnd_b),
      .h_walls(h_b), .v_walls(v_b), .busy(busy_b), .done(done_b)
   );

   task automatic check(input string tag, input longint obs, input longint exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cmp_vec(input string tag, input logic [1055:0] obs, input logic [1055:0] exp);
      int first;
      int nd;
      first = -1;
      nd = 0;
      for (int i = 0; i < 1056; i++) begin
         if (obs[i] !== exp[i]) begin
            nd++;
            if (first < 0) first = i;
         end
      end
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: %0d bits differ, first bit %0d observed %b expected %b",
                tag, nd, first, obs[first], exp[first]);
      end
   endtask

   function automatic logic [1055:0] ones_vec(input int n);
      logic [1055:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v[i] = 1'b1;
      return v;
   endfunction

   // depth-first walk on a row/column grid with an explicit stack of coordinates
   task automatic model(input int w, input int h, input bit zero_rnd,
                        output logic [1055:0] eh, output logic [1055:0] ev, output int picks);
      bit vis [32][32];
      int sr[$];
      int sc[$];
      int r, c, k, d, s;
      bit ok [4];
      bit found;
      eh = ones_vec((h + 1) * w);
      ev = ones_vec(h * (w + 1));
      eh[0] = 1'b0;
      eh[h * w + w - 1] = 1'b0;
      for (int i = 0; i < 32; i++)
         for (int j = 0; j < 32; j++) vis[i][j] = 1'b0;
      r = 0; c = 0; k = 0; d = 0;
      vis[0][0] = 1'b1;
      while (k < 8 * w * h) begin
         ok[0] = (r > 0)     && !vis[r-1][c];
         ok[1] = (c < w - 1) && !vis[r][c+1];
         ok[2] = (r < h - 1) && !vis[r+1][c];
         ok[3] = (c > 0)     && !vis[r][c-1];
         s = (zero_rnd || k >= NSEQ) ? 0 : int'(seq[k][1:0]);
         found = 1'b0;
         for (int i = 0; i < 4 && !found; i++) begin
            d = (s + i) % 4;
            if (ok[d]) found = 1'b1;
         end
         k++;
         if (found) begin
            sr.push_back(r);
            sc.push_back(c);
            case (d)
               0: begin eh[r * w + c] = 1'b0;         r = r - 1; end
               1: begin ev[r * (w + 1) + c + 1] = 1'b0; c = c + 1; end
               2: begin eh[(r + 1) * w + c] = 1'b0;   r = r + 1; end
               default: begin ev[r * (w + 1) + c] = 1'b0; c = c - 1; end
            endcase
            vis[r][c] = 1'b1;
         end else if (sr.size() > 0) begin
            r = sr.pop_back();
            c = sc.pop_back();
         end else begin
            break;
         end
      end
      picks = k;
   endtask

   task automatic reach(input logic [1055:0] hw, input logic [1055:0] vw,
                        input int w, input int h, output int cnt);
      bit seen [32][32];
      int qr[$];
      int qc[$];
      int r, c;
      for (int i = 0; i < 32; i++)
         for (int j = 0; j < 32; j++) seen[i][j] = 1'b0;
      seen[0][0] = 1'b1;
      qr.push_back(0);
      qc.push_back(0);
      cnt = 0;
      while (qr.size() > 0) begin
         r = qr.pop_front();
         c = qc.pop_front();
         cnt++;
         if (r > 0 && !hw[r*w+c] && !seen[r-1][c]) begin
            seen[r-1][c] = 1'b1; qr.push_back(r-1); qc.push_back(c);
         end
         if (r < h-1 && !hw[(r+1)*w+c] && !seen[r+1][c]) begin
            seen[r+1][c] = 1'b1; qr.push_back(r+1); qc.push_back(c);
         end
         if (c > 0 && !vw[r*(w+1)+c] && !seen[r][c-1]) begin
            seen[r][c-1] = 1'b1; qr.push_back(r); qc.push_back(c-1);
         end
         if (c < w-1 && !vw[r*(w+1)+c+1] && !seen[r][c+1]) begin
            seen[r][c+1] = 1'b1; qr.push_back(r); qc.push_back(c+1);
         end
      end
   endtask

   task automatic wall_stats(input logic [1055:0] hw, input logic [1055:0] vw,
                             input int w, input int h, output int clr, output int bset);
      clr = 0;
      bset = 0;
      for (int r = 1; r < h; r++)
         for (int c = 0; c < w; c++) if (!hw[r*w+c]) clr++;
      for (int r = 0; r < h; r++)
         for (int c = 1; c < w; c++) if (!vw[r*(w+1)+c]) clr++;
      for (int c = 0; c < w; c++) bset += int'(hw[c]) + int'(hw[h*w+c]);
      for (int r = 0; r < h; r++) bset += int'(vw[r*(w+1)]) + int'(vw[r*(w+1)+w]);
   endtask

   // one start on dut_a; rnd stream aligned so seq[k] is present on the k-th PICK cycle
   task automatic run_a(input bit hold, input int abort_pick,
                        output int bcnt, output int dcnt, output int dpos, output bit again);
      bcnt = 0; dcnt = 0; dpos = -1; again = 1'b0;
      @(negedge clk);
      start_a = 1'b1;
      rnd_a = 8'h00;
      @(posedge clk);
      for (int c = 0; c < 2 * NA + 8; c++) begin
         @(negedge clk);
         if (!hold) start_a = 1'b0;
         if (c >= 1 && c - 1 < NSEQ) rnd_a = seq[c-1];
         if (busy_a && dpos < 0) bcnt++;
         if (done_a) begin
            dcnt++;
            if (dpos < 0) dpos = c;
         end
         if (hold && dpos >= 0 && c == dpos + 2 && busy_a) again = 1'b1;
         if (abort_pick >= 0 && c == abort_pick + 1) begin
            #1 rst = 1'b0;
            break;
         end
         if (dpos >= 0 && c >= dpos + 2) break;
      end
      start_a = 1'b0;
   endtask

   task automatic check_big_maze(input string tag, input logic [1055:0] eh, input logic [1055:0] ev);
      int clr, bset, cnt;
      cmp_vec({tag, "_h_walls"}, 1056'(h_a), eh);
      cmp_vec({tag, "_v_walls"}, 1056'(v_a), ev);
      wall_stats(1056'(h_a), 1056'(v_a), WA, HA, clr, bset);
      check({tag, "_interior_cleared"}, clr, NA - 1);
      check({tag, "_border_set"}, bset, 2 * (WA + HA) - 2);
      check({tag, "_entry_open"}, h_a[0], 0);
      check({tag, "_exit_open"}, h_a[HA*WA + WA - 1], 0);
      reach(1056'(h_a), 1056'(v_a), WA, HA, cnt);
      check({tag, "_bfs_reach"}, cnt, NA);
   endtask

   initial begin
      logic [1055:0] eh_a, ev_a, eh_b, ev_b;
      int picks_a, picks_b, bc, dc, dp, clr, bset, cnt;
      bit again;

      void'($urandom(217));
      for (int i = 0; i < NSEQ; i++) seq[i] = 8'($urandom);
      model(WA, HA, 1'b0, eh_a, ev_a, picks_a);
      model(WB, HB, 1'b1, eh_b, ev_b, picks_b);

      // asynchronous reset with no clock edge
      #1 rst = 1'b0;
      #1;
      cmp_vec("rst_h_a", 1056'(h_a), ones_vec((HA+1)*WA));
      cmp_vec("rst_v_a", 1056'(v_a), ones_vec(HA*(WA+1)));
      check("rst_busy_a", busy_a, 0);
      check("rst_done_a", done_a, 0);
      cmp_vec("rst_h_b", 1056'(h_b), ones_vec((HB+1)*WB));
      check("rst_busy_b", busy_b, 0);

      // release; nothing moves without start
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("idle_busy_a", busy_a, 0);
      check("idle_done_a", done_a, 0);
      cmp_vec("idle_h_a", 1056'(h_a), ones_vec((HA+1)*WA));

      // 2x2 with rnd held at zero
      bc = 0; dc = 0; dp = -1;
      @(negedge clk);
      start_b = 1'b1;
      rnd_b = 8'h00;
      @(posedge clk);
      for (int c = 0; c < 2 * NB + 8; c++) begin
         @(negedge clk);
         start_b = 1'b0;
         if (busy_b && dp < 0) bc++;
         if (done_b) begin
            dc++;
            if (dp < 0) dp = c;
         end
         if (dp >= 0 && c >= dp + 2) break;
      end
      check("b_busy_cycles", bc, 2 * NB);
      check("b_done_pos", dp, 2 * NB);
      check("b_done_count", dc, 1);
      check("b_model_picks", picks_b, 2 * NB - 1);
      check("b_v1", v_b[1], 0);
      check("b_h3", h_b[3], 0);
      check("b_v4", v_b[4], 0);
      wall_stats(1056'(h_b), 1056'(v_b), WB, HB, clr, bset);
      check("b_interior_cleared", clr, NB - 1);
      cmp_vec("b_h_walls", 1056'(h_b), eh_b);
      cmp_vec("b_v_walls", 1056'(v_b), ev_b);

      // 10x15 seeded run
      run_a(1'b0, -1, bc, dc, dp, again);
      check("a1_busy_cycles", bc, 1 + picks_a);
      check("a1_busy_2n", bc, 2 * NA);
      check("a1_done_pos", dp, 2 * NA);
      check("a1_done_count", dc, 1);
      check_big_maze("a1", eh_a, ev_a);

      // replay the same stream
      run_a(1'b0, -1, bc, dc, dp, again);
      check("a2_busy_cycles", bc, 2 * NA);
      check("a2_done_count", dc, 1);
      cmp_vec("a2_h_walls", 1056'(h_a), eh_a);
      cmp_vec("a2_v_walls", 1056'(v_a), ev_a);

      // abort at PICK cycle 50
      run_a(1'b0, 50, bc, dc, dp, again);
      #1;
      cmp_vec("abort_h_a", 1056'(h_a), ones_vec((HA+1)*WA));
      cmp_vec("abort_v_a", 1056'(v_a), ones_vec(HA*(WA+1)));
      check("abort_busy", busy_a, 0);
      dc = dc + int'(done_a);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         dc = dc + int'(done_a);
      end
      check("abort_no_done", dc, 0);
      rst = 1'b1;
      run_a(1'b0, -1, bc, dc, dp, again);
      check("a3_busy_cycles", bc, 2 * NA);
      check("a3_done_count", dc, 1);
      check_big_maze("a3", eh_a, ev_a);

      // start held high through a run
      run_a(1'b1, -1, bc, dc, dp, again);
      check("hold_busy_cycles", bc, 2 * NA);
      check("hold_done_count", dc, 1);
      check("hold_done_pos", dp, 2 * NA);
      check("hold_restart", again, 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
